// File: rtl/mar_arbiter.sv
//==============================================================================
// mar_arbiter : round-robin sequencer for a two-stage memory address register
// Revision    : 1.0
//==============================================================================
`default_nettype none

module mar_arbiter #(
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_ack,
  output logic [AW-1:0] mar_addr,
  output logic          mar_en,
  output logic          mar_en1,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          err,
  output logic          busy,
  output logic          gnt_d
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_XFER = 3'd2,
    S_MEM  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic          gnt_q, gnt_nxt;
  logic [7:0]    cnt, cnt_nxt;
  logic          to_flag, to_flag_nxt;
  logic          win_d;

  // On a tie the requester not served last wins.
  assign win_d = (f_req && d_req) ? ~gnt_q : d_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      gnt_q   <= 1'b0;
      cnt     <= '0;
      to_flag <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      gnt_q   <= gnt_nxt;
      cnt     <= cnt_nxt;
      to_flag <= to_flag_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    gnt_nxt     = gnt_q;
    cnt_nxt     = cnt;
    to_flag_nxt = to_flag;
    case (state)
      S_IDLE: begin
        if (f_req || d_req) begin
          gnt_nxt   = win_d;
          addr_nxt  = win_d ? d_addr : f_addr;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_XFER;
      S_XFER: begin
        cnt_nxt   = '0;
        state_nxt = S_MEM;
      end
      S_MEM: begin
        cnt_nxt = cnt + 8'd1;
        // A late ack on the final wait cycle still counts as success.
        if (mem_ack) begin
          to_flag_nxt = 1'b0;
          state_nxt   = S_DONE;
        end else if (cnt == CNT_LAST) begin
          to_flag_nxt = 1'b1;
          state_nxt   = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mar_addr = addr_q;
  assign mar_en   = (state == S_LOAD);
  assign mar_en1  = (state == S_XFER);
  assign mem_req  = (state == S_MEM);
  assign f_ack    = (state == S_DONE) && !gnt_q;
  assign d_ack    = (state == S_DONE) &&  gnt_q;
  assign err      = (state == S_DONE) &&  to_flag;
  assign busy     = (state != S_IDLE);
  assign gnt_d    = gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mar_arbiter.sv
//==============================================================================
// tb_mar_arbiter : directed and randomized bench for mar_arbiter
// Revision       : 1.0
//==============================================================================
`default_nettype none

module tb_mar_arbiter;

  localparam int AW      = 16;
  localparam int TIMEOUT = 15;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          f_req   = 1'b0;
  logic          d_req   = 1'b0;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] f_addr  = '0;
  logic [AW-1:0] d_addr  = '0;
  logic          f_ack, d_ack, mar_en, mar_en1, mem_req, err, busy, gnt_d;
  logic [AW-1:0] mar_addr;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mar_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack),
    .mar_addr(mar_addr), .mar_en(mar_en), .mar_en1(mar_en1),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .err(err), .busy(busy), .gnt_d(gnt_d)
  );

  wire [AW+7:0] act_bus = {mar_addr, mar_en, mar_en1, mem_req, f_ack, d_ack, err, busy, gnt_d};

  // Transaction-level reference: a grant starts a timeline measured in
  // cycles since the grant edge; done_at is the offset of the ack cycle.
  logic          m_active, m_last, m_err;
  int            m_off, m_done_at;
  logic [AW-1:0] m_addr;

  task automatic model_reset();
    m_active = 1'b0; m_last = 1'b0; m_err = 1'b0;
    m_off = 0; m_done_at = 0; m_addr = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else if (!m_active) begin
        if (f_req || d_req) begin
          m_last    = (f_req && d_req) ? !m_last : d_req;
          m_addr    = m_last ? d_addr : f_addr;
          m_active  = 1'b1;
          m_off     = 1;
          m_done_at = 0;
        end
      end else if (m_off == m_done_at) begin
        m_active = 1'b0; m_off = 0; m_done_at = 0;
      end else begin
        if (m_off >= 3 && m_done_at == 0) begin
          if (mem_ack) begin
            m_done_at = m_off + 1; m_err = 1'b0;
          end else if (m_off - 3 == TIMEOUT - 1) begin
            m_done_at = m_off + 1; m_err = 1'b1;
          end
        end
        m_off++;
      end
    end
  end

  function automatic logic [AW+7:0] expected_outputs();
    logic ack;
    ack = m_active && m_done_at != 0 && m_off == m_done_at;
    return {m_addr, m_active && m_off == 1, m_active && m_off == 2,
            m_active && m_off >= 3 && (m_done_at == 0 || m_off < m_done_at),
            ack && !m_last, ack && m_last, ack && m_err, m_active, m_last};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if (act_bus !== expected_outputs()) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t: got %h expected %h", $time, act_bus, expected_outputs());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Counts cycles from the next grant edge up to and including the ack cycle.
  task automatic wait_ack(output int n, output int c_en, output int c_en1, output int c_mr,
                          output int mr_cnt, output logic fa, output logic da,
                          output logic e, output logic [AW-1:0] a_mr);
    n = 0; c_en = 0; c_en1 = 0; c_mr = 0; mr_cnt = 0; a_mr = '0;
    fa = 1'b0; da = 1'b0; e = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (mar_en  && c_en  == 0) c_en  = n;
      if (mar_en1 && c_en1 == 0) c_en1 = n;
      if (mem_req) begin
        mr_cnt++;
        if (c_mr == 0) begin c_mr = n; a_mr = mar_addr; end
      end
      if (f_ack || d_ack) begin
        fa = f_ack; da = d_ack; e = err;
        break;
      end
      if (n >= 300) begin
        vectors++; miscompares++;
        $display("FAIL ack_wait: no ack after %0d cycles, required within %0d", n, TIMEOUT + 4);
        break;
      end
    end
  endtask

  int n, n_tot, c_en, c_en1, c_mr, mr_cnt, m;
  logic fa, da, e;
  logic [AW-1:0] a_mr;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {8'd0, act_bus}, 32'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single fetch with immediate memory ack.
    f_req = 1'b1; f_addr = 16'h1234; mem_ack = 1'b1;
    wait_ack(n, c_en, c_en1, c_mr, mr_cnt, fa, da, e, a_mr);
    check("fetch_ack_cycle", n, 4);
    check("fetch_en_cycle", c_en, 1);
    check("fetch_en1_cycle", c_en1, 2);
    check("fetch_memreq_cycle", c_mr, 3);
    check("fetch_addr", {16'd0, a_mr}, 32'h1234);
    check("fetch_ack_flags", {29'd0, fa, da, e}, 32'b100);
    f_req = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Tie after reset: data, fetch, data.
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0055; d_addr = 16'h00AA; mem_ack = 1'b1;
    wait_ack(n, c_en, c_en1, c_mr, mr_cnt, fa, da, e, a_mr);
    n_tot = n;
    check("tie1_cycle", n_tot, 4);
    check("tie1_owner", {30'd0, fa, da}, 32'b01);
    check("tie1_addr", {16'd0, a_mr}, 32'h00AA);
    wait_ack(n, c_en, c_en1, c_mr, mr_cnt, fa, da, e, a_mr);
    n_tot += n;
    check("tie2_cycle", n_tot, 9);
    check("tie2_owner", {30'd0, fa, da}, 32'b10);
    check("tie2_addr", {16'd0, a_mr}, 32'h0055);
    wait_ack(n, c_en, c_en1, c_mr, mr_cnt, fa, da, e, a_mr);
    n_tot += n;
    check("tie3_cycle", n_tot, 14);
    check("tie3_owner", {30'd0, fa, da}, 32'b01);
    f_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout with no memory ack.
    d_req = 1'b1; d_addr = 16'h0BEE;
    wait_ack(n, c_en, c_en1, c_mr, mr_cnt, fa, da, e, a_mr);
    check("timeout_memreq_cycles", mr_cnt, TIMEOUT);
    check("timeout_flags", {29'd0, fa, da, e}, 32'b011);
    d_req = 1'b0;
    @(negedge clk);
    check("timeout_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);

    // Stray acks before MEM, address change in XFER, req dropped in MEM.
    mem_ack = 1'b1;
    @(negedge clk);
    check("stray_idle_busy", {31'd0, busy}, 32'd0);
    f_req = 1'b1; f_addr = 16'h4321;
    @(negedge clk);
    check("stray_load_en", {31'd0, mar_en}, 32'd1);
    @(negedge clk);
    check("stray_xfer_en1", {30'd0, mar_en1, mar_en}, 32'b10);
    f_addr = 16'hFFFF;
    @(negedge clk);
    check("stray_mem_addr", {15'd0, mem_req, mar_addr}, 32'h1_4321);
    f_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check("stray_mem_waits", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    @(negedge clk);
    check("stray_ack_flags", {29'd0, f_ack, d_ack, err}, 32'b100);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Ack on the last allowed MEM cycle.
    d_req = 1'b1; d_addr = 16'h0F0F; m = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req) begin
        m++;
        mem_ack = (m == TIMEOUT);
      end else if (m > 0) break;
    end
    check("boundary_memreq_cycles", m, TIMEOUT);
    check("boundary_flags", {29'd0, f_ack, d_ack, err}, 32'b010);
    d_req = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of MEM, then restart.
    d_req = 1'b1; d_addr = 16'h2468;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_outputs", {8'd0, act_bus}, 32'd0);
    @(negedge clk);
    check("rst_hold_outputs", {8'd0, act_bus}, 32'd0);
    #1 rst_n = 1'b1; mem_ack = 1'b1;
    wait_ack(n, c_en, c_en1, c_mr, mr_cnt, fa, da, e, a_mr);
    check("rst_restart_cycle", n, 4);
    check("rst_restart_en", c_en, 1);
    check("rst_restart_flags", {29'd0, fa, da, e}, 32'b010);
    d_req = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      rst_n = rst_n ? ($urandom_range(0, 799) != 0) : 1'b1;
      if (f_ack)                                    f_req = ($urandom_range(0, 7) == 0);
      else if (!f_req && $urandom_range(0, 3) == 0) f_req = 1'b1;
      else if (f_req && $urandom_range(0, 49) == 0) f_req = 1'b0;
      if (d_ack)                                    d_req = ($urandom_range(0, 7) == 0);
      else if (!d_req && $urandom_range(0, 3) == 0) d_req = 1'b1;
      else if (d_req && $urandom_range(0, 49) == 0) d_req = 1'b0;
      if ($urandom_range(0, 3) == 0) f_addr = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d_addr = 16'($urandom);
      mem_ack = ($urandom_range(0, 99) < 20);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mar_arbiter.md
# mar_arbiter

Sequencer and two-way arbiter for the 16-bit memory address register (MAR100-style two-stage register: `en` loads the staging register, `en1` transfers it to the output address). Shares the MAR between the instruction-fetch requester and the load/store requester with round-robin arbitration. Drives the MAR load/transfer strobes in the required order and runs a request/acknowledge handshake with the memory. Returns a one-cycle acknowledge, or a timeout error, to the requester it served.

## Interface
- `AW`, 16: address width (MAR width).
- `TIMEOUT`, 15: maximum cycles spent in MEM waiting for `mem_ack`; range 1..255.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `f_req` input 1: fetch request (level, held until `f_ack`).
- `f_addr` input AW: fetch address.
- `f_ack` output 1: one-cycle done pulse to fetch.
- `d_req` input 1: data request (level, held until `d_ack`).
- `d_addr` input AW: data address.
- `d_ack` output 1: one-cycle done pulse to data.
- `mar_addr` output AW: address presented to MAR `addr`.
- `mar_en` output 1: MAR staging load strobe (MAR `en`).
- `mar_en1` output 1: MAR transfer strobe (MAR `en1`).
- `mem_req` output 1: memory access request; MAR output is valid while high.
- `mem_ack` input 1: memory done.
- `err` output 1: one-cycle timeout pulse, coincident with the ack.
- `busy` output 1: high in any state other than IDLE.
- `gnt_d` output 1: current/last grant owner (1 = data, 0 = fetch).

## Operation
- FSM states: IDLE, LOAD, XFER, MEM, DONE. All outputs are decoded from registered state plus registered `addr_q`, `gnt_d`, `to_flag`, and are glitch-free Moore outputs.
- **IDLE.** If `f_req | d_req` at the clock edge:
  - Choose the winner. Only one requester high: grant it. Both high: grant the one not served last (`gnt_d` inverted).
  - Capture the winner's address into `addr_q`, update `gnt_d`, go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD.** `mar_en`=1. Go to XFER.
- **XFER.** `mar_en1`=1, `mar_en`=0 (MAR requires `en` low for transfer). Go to MEM.
- **MEM.** `mem_req`=1. The wait counter clears on MEM entry and increments each MEM cycle.
  - `mem_ack` sampled high: go to DONE with `to_flag`=0.
  - Counter reaches TIMEOUT-1 without ack: go to DONE with `to_flag`=1.
  - Ack and timeout in the same cycle: ack wins (`to_flag`=0).
- **DONE.** Pulse `d_ack` if `gnt_d`, else `f_ack`. `err`=`to_flag`. Go to IDLE.
- `mar_addr` = `addr_q` in every state. `addr_q` changes only on IDLE→LOAD, so the address is stable across LOAD/XFER/MEM.
- `mem_ack` is ignored outside MEM.
- Changes to `req`/`addr` inputs after the grant are ignored. The transaction completes and the ack still pulses even if `req` dropped.
- A `req` still high when back in IDLE is treated as a new request. Requesters drop `req` in the cycle after their ack.
- At most one of `mar_en`, `mar_en1`, `mem_req`, `f_ack`, `d_ack` is high in any cycle.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State returns to IDLE.
  - `addr_q`=0, `gnt_d`=0, counter=0, `to_flag`=0.
  - All outputs 0: `mar_addr`=0, strobes 0, `f_ack`=`d_ack`=`err`=`busy`=0.
- Reset asserted mid-transaction aborts it immediately. No ack is issued for the aborted transaction.
- With `gnt_d`=0 after reset, the first tie goes to data.
- Latency, with `req` sampled at edge E0:
  - LOAD in cycle 1, XFER in cycle 2, MEM from cycle 3.
  - MAR output is valid from cycle 3.
  - With `mem_ack` high in cycle 3, ack pulses in cycle 4 and IDLE is re-entered in cycle 5.
  - Minimum request-to-ack: 4 cycles. Back-to-back service period: 5 cycles.
- Timeout: `mem_req` stays high for exactly TIMEOUT cycles, then DONE with `err`=1.

## Test plan
- **Single fetch.** `f_req`=1, `f_addr`=0x1234, `mem_ack` high in first MEM cycle → `mar_en` cycle 1, `mar_en1` cycle 2, `mem_req` cycle 3 with `mar_addr`=0x1234, `f_ack`=1 cycle 4, `err`=0, `d_ack`=0 throughout.
- **Tie after reset, then fairness.** `f_req`=`d_req`=1 continuously, `d_addr`=0x00AA, `f_addr`=0x0055, immediate acks → grants alternate data, fetch, data; `d_ack` cycle 4, `f_ack` cycle 9, `d_ack` cycle 14; `mar_addr` follows 0x00AA/0x0055.
- **Timeout.** `d_req`=1, `mem_ack` never asserted, TIMEOUT=15 → `mem_req` high exactly 15 cycles, then `d_ack`=1 and `err`=1 in the same cycle, then `busy`=0.
- **Stray ack / input change.**
  - `mem_ack` pulsed during IDLE, LOAD and XFER is ignored and MEM still waits.
  - `f_addr` changed to 0xFFFF during XFER leaves `mar_addr` unchanged.
  - `f_req` dropped in MEM still yields `f_ack`.
- **Ack on timeout boundary.** `mem_ack` arrives in the 15th MEM cycle → ack with `err`=0.
- **Reset mid-MEM.** `rst_n` low during MEM → all outputs 0 immediately, no ack. After release with `d_req`=1 the sequence restarts from LOAD with a 4-cycle ack.
